// File: rtl/fib_sequencer_if.sv
// fib_sequencer_if: front-end handshake plus shared alu8 bus for fib_sequencer
// Front end: start, n (request); busy, done, fib_out, overflow (status/result).
// ALU bus: alu_left, alu_right, alu_status_in, alu_opcode (to alu8); alu_status_out, alu_result (from alu8).
// modport slave is the sequencer; modport master is its environment (front end + alu8).
interface fib_sequencer_if #(parameter int NBYTES = 2, parameter int NIDX_W = 6) ();
  logic start;
  logic [NIDX_W-1:0] n;
  logic busy;
  logic done;
  logic [8*NBYTES-1:0] fib_out;
  logic overflow;
  logic [7:0] alu_left;
  logic [7:0] alu_right;
  logic alu_status_in;
  logic [1:0] alu_opcode;
  logic alu_status_out;
  logic [7:0] alu_result;
  modport slave (
    input start, n, alu_status_out, alu_result,
    output busy, done, fib_out, overflow, alu_left, alu_right, alu_status_in, alu_opcode
  );
  modport master (
    output start, n, alu_status_out, alu_result,
    input busy, done, fib_out, overflow, alu_left, alu_right, alu_status_in, alu_opcode
  );
endinterface

// File: rtl/fib_sequencer.sv
// fib_sequencer: computes Fib(n) by driving a shared 8-bit ALU one byte per cycle
// Ports: clk, rst_n (sync, active-low), bus (fib_sequencer_if.slave: start/n in,
//   busy/done/fib_out/overflow out, alu_* operands out, alu_result/alu_status_out in).
// Option: FIB_EARLY_ABORT_EN stops at the first overflowing iteration and saturates fib_out.
module fib_sequencer #(
  parameter int NBYTES = 2,
  parameter int NIDX_W = 6
) (
  input logic clk,
  input logic rst_n,
  fib_sequencer_if.slave bus
);
  localparam int W = 8 * NBYTES;
  localparam int KW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, ADD = 3'd2, UPD = 3'd3, DONE = 3'd4;
  logic [2:0] state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, t_q, t_d, fib_q, fib_d;
  logic [NIDX_W-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic c_q, c_d, ovf_q, ovf_d;
  logic last_k, ovf_set, abort;
  assign last_k = int'(k_q) == NBYTES - 1;
  // top-byte carry only counts as overflow when it is not the final iteration
  assign ovf_set = state_q == UPD && c_q && cnt_q != NIDX_W'(1);
`ifdef FIB_EARLY_ABORT_EN
  assign abort = ovf_set;
`else
  assign abort = 1'b0;
`endif
  assign bus.alu_left = state_q == ADD ? a_q[8*k_q +: 8] : 8'h00;
  assign bus.alu_right = state_q == ADD ? b_q[8*k_q +: 8] : 8'h00;
  assign bus.alu_status_in = state_q == ADD && k_q != '0 && c_q;
  assign bus.alu_opcode = 2'b00;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.fib_out = fib_q;
  assign bus.overflow = ovf_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    t_d = t_q;
    fib_d = fib_q;
    cnt_d = cnt_q;
    k_d = k_q;
    c_d = c_q;
    ovf_d = ovf_q | ovf_set;
    case (state_q)
      IDLE: if (bus.start) begin
        cnt_d = bus.n;
        ovf_d = 1'b0;
        state_d = INIT;
      end
      INIT: begin
        a_d = '0;
        b_d = W'(1);
        k_d = '0;
        c_d = 1'b0;
        state_d = cnt_q == '0 ? DONE : ADD;
        fib_d = cnt_q == '0 ? '0 : fib_q;
      end
      ADD: begin
        t_d[8*k_q +: 8] = bus.alu_result;
        c_d = bus.alu_status_out;
        k_d = k_q + 1'b1;
        state_d = last_k ? UPD : ADD;
      end
      UPD: begin
        a_d = b_q;
        b_d = t_q;
        cnt_d = cnt_q - 1'b1;
        k_d = '0;
        state_d = (cnt_q == NIDX_W'(1) || abort) ? DONE : ADD;
        fib_d = abort ? '1 : (cnt_q == NIDX_W'(1) ? b_q : fib_q);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      t_q <= '0;
      fib_q <= '0;
      cnt_q <= '0;
      k_q <= '0;
      c_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      t_q <= t_d;
      fib_q <= fib_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      c_q <= c_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_fib_sequencer.sv
// tb_fib_sequencer: scoreboard bench for fib_sequencer with a behavioural alu8
module tb_fib_sequencer;
  typedef struct {
    logic [15:0] fib;
    logic ovf;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  fib_sequencer_if #(.NBYTES(2), .NIDX_W(6)) bus ();
  fib_sequencer #(.NBYTES(2), .NIDX_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign {bus.alu_status_out, bus.alu_result} = {1'b0, bus.alu_left} + {1'b0, bus.alu_right} + {8'h00, bus.alu_status_in};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input int nn);
    exp_t e;
    longint f[0:64];
    int m = 0;
    f[0] = 0;
    f[1] = 1;
    for (int i = 2; i <= 64; i++) f[i] = f[i-1] + f[i-2];
    for (int i = 64; i >= 0; i--) if (f[i] > 65535) m = i;
    e.ovf = f[nn] > 65535;
    e.fib = 16'(f[nn]);
    e.lat = 2 + nn * 3;
`ifdef FIB_EARLY_ABORT_EN
    if (e.ovf) begin
      e.fib = 16'hFFFF;
      e.lat = 2 + (m - 1) * 3;
    end
`endif
    return e;
  endfunction
  task automatic run(input int nn, input int ign_at);
    exp_t e;
    int cyc = 1;
    int alu_act = 0;
    bit got = 0;
    bit carry_next = 0;
    sb.push_back(model(nn));
    bus.start = 1'b1;
    bus.n = 6'(nn);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    while (!got && cyc < 300) begin
      if (bus.alu_left != 0 || bus.alu_right != 0 || bus.alu_status_in) alu_act++;
      if (carry_next) begin
        check("byte1_status_in", 32'(bus.alu_status_in), 32'd1);
        check("byte1_result", 32'(bus.alu_result), 32'h01);
        check("opcode", 32'(bus.alu_opcode), 32'd0);
        carry_next = 0;
      end
      if (nn == 14 && bus.alu_left == 8'h90 && bus.alu_right == 8'hE9) carry_next = 1;
      if (bus.done) got = 1;
      else begin
        if (cyc == 1 && !bus.busy) check("busy_cycle1", 32'(bus.busy), 32'd1);
        bus.start = cyc == ign_at;
        bus.n = cyc == ign_at ? 6'd5 : 6'(nn);
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    if (!got) check($sformatf("timeout_n%0d", nn), 32'd0, 32'd1);
    else begin
      check($sformatf("latency_n%0d", nn), 32'(cyc), 32'(e.lat));
      check($sformatf("fib_n%0d", nn), 32'(bus.fib_out), 32'(e.fib));
      check($sformatf("ovf_n%0d", nn), 32'(bus.overflow), 32'(e.ovf));
      check($sformatf("busy_done_n%0d", nn), 32'(bus.busy), 32'd1);
      if (nn == 0) check("alu_idle_n0", 32'(alu_act), 32'd0);
      @(negedge clk);
      check($sformatf("done_pulse_n%0d", nn), 32'(bus.done), 32'd0);
      check($sformatf("fib_hold_n%0d", nn), 32'(bus.fib_out), 32'(e.fib));
      check($sformatf("idle_busy_n%0d", nn), 32'(bus.busy), 32'd0);
    end
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_fib"}, 32'(bus.fib_out), 32'd0);
    check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    check({tag, "_alu"}, {14'd0, bus.alu_opcode, bus.alu_status_in, bus.alu_left, bus.alu_right}, 32'd0);
  endtask
  initial begin
    int dones = 0;
    bus.start = 1'b0;
    bus.n = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    run(0, -1);
    run(1, -1);
    run(10, 3);
    run(14, -1);
    run(24, -1);
    run(25, -1);
    run(2, -1);
    sb.push_back(model(10));
    bus.start = 1'b1;
    bus.n = 6'd10;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrun_reset");
    void'(sb.pop_front());
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("no_done_after_reset", 32'(dones), 32'd0);
    run(3, -1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
